// File: rtl/rect_cmd_writer_if.sv
// Request, draw-queue and status bundle for rect_cmd_writer.
// The writer sits on the slave side. The requester or bench sits on the master side.
interface rect_cmd_writer_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_top;
  logic [6:0]  req_bottom;
  logic [7:0]  req_left;
  logic [7:0]  req_right;
  logic [2:0]  req_color;
  logic        req_swap;
  logic        full;
  logic        we;
  logic [15:0] data;
  logic        busy;
  logic [6:0]  lines_sent;
  logic [1:0]  dbg_state;

  modport slave (
    input  req_valid, req_top, req_bottom, req_left, req_right, req_color, req_swap, full,
    output req_ready, we, data, busy, lines_sent, dbg_state
  );

  modport master (
    output req_valid, req_top, req_bottom, req_left, req_right, req_color, req_swap, full,
    input  req_ready, we, data, busy, lines_sent, dbg_state
  );
endinterface

// File: rtl/rect_cmd_writer.sv
// Rectangle command writer: turns a fill or swap request into header/span words for a draw queue.
// Optional macro RECT_CMD_CLIP_EN clamps lines to 119 and columns to 159 when a request is accepted.
module rect_cmd_writer (
  input  logic             clk,
  input  logic             reset,
  rect_cmd_writer_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, SPAN = 2'd2} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [6:0]  r_line;
  logic [6:0]  r_bottom;
  logic [7:0]  r_left;
  logic [7:0]  r_right;
  logic [2:0]  r_color;
  logic        r_swap;
  logic        r_we;
  logic [15:0] r_data;
  logic [6:0]  r_lines_sent;

  logic [6:0]  w_top_c;
  logic [6:0]  w_bot_c;
  logic [7:0]  w_left_c;
  logic [7:0]  w_right_c;
  logic [6:0]  w_top_o;
  logic [6:0]  w_bot_o;
  logic [7:0]  w_left_o;
  logic [7:0]  w_right_o;
  logic        w_load;
  logic [6:0]  w_line_nxt;
  logic [6:0]  w_lines_nxt;
  logic [15:0] w_data_nxt;

`ifdef RECT_CMD_CLIP_EN
  assign w_top_c   = (bus.req_top    > 7'd119) ? 7'd119 : bus.req_top;
  assign w_bot_c   = (bus.req_bottom > 7'd119) ? 7'd119 : bus.req_bottom;
  assign w_left_c  = (bus.req_left   > 8'd159) ? 8'd159 : bus.req_left;
  assign w_right_c = (bus.req_right  > 8'd159) ? 8'd159 : bus.req_right;
`else
  assign w_top_c   = bus.req_top;
  assign w_bot_c   = bus.req_bottom;
  assign w_left_c  = bus.req_left;
  assign w_right_c = bus.req_right;
`endif

  // Order the clamped coordinates so the line walk always runs top to bottom.
  assign w_top_o   = (w_top_c  > w_bot_c)   ? w_bot_c   : w_top_c;
  assign w_bot_o   = (w_top_c  > w_bot_c)   ? w_top_c   : w_bot_c;
  assign w_left_o  = (w_left_c > w_right_c) ? w_right_c : w_left_c;
  assign w_right_o = (w_left_c > w_right_c) ? w_left_c  : w_right_c;

  // Handshakes: a request transfers on a rising edge with req_valid & req_ready.
  // A word transfers on a rising edge with we & !full. While full is high, state, we and data hold.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_line_nxt  = r_line;
    w_lines_nxt = r_lines_sent;
    w_data_nxt  = r_data;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_load      = 1'b1;
          w_state_nxt = HDR;
          w_line_nxt  = w_top_o;
          w_lines_nxt = 7'd0;
          w_data_nxt  = bus.req_swap ? {2'b01, 3'b000, 4'b0000, 7'd0}
                                     : {2'b00, bus.req_color, 4'b0000, w_top_o};
        end
      end
      HDR: begin
        if (!bus.full) begin
          if (r_swap) begin
            w_state_nxt = IDLE;
            w_data_nxt  = 16'h0000;
          end else begin
            w_state_nxt = SPAN;
            w_data_nxt  = {r_left, r_right};
          end
        end
      end
      SPAN: begin
        if (!bus.full) begin
          w_lines_nxt = (r_lines_sent == 7'd127) ? r_lines_sent : r_lines_sent + 7'd1;
          if (r_line < r_bottom) begin
            w_state_nxt = HDR;
            w_line_nxt  = r_line + 7'd1;
            w_data_nxt  = {2'b00, r_color, 4'b0000, r_line + 7'd1};
          end else begin
            w_state_nxt = IDLE;
            w_data_nxt  = 16'h0000;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_data_nxt  = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_data       <= 16'h0000;
      r_line       <= 7'd0;
      r_lines_sent <= 7'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_we         <= (w_state_nxt != IDLE);
      r_data       <= w_data_nxt;
      r_line       <= w_line_nxt;
      r_lines_sent <= w_lines_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bottom <= 7'd0;
      r_left   <= 8'd0;
      r_right  <= 8'd0;
      r_color  <= 3'd0;
      r_swap   <= 1'b0;
    end else if (w_load) begin
      r_bottom <= w_bot_o;
      r_left   <= w_left_o;
      r_right  <= w_right_o;
      r_color  <= bus.req_color;
      r_swap   <= bus.req_swap;
    end
  end

  assign bus.req_ready  = (r_state == IDLE) & reset;
  assign bus.busy       = (r_state != IDLE);
  assign bus.we         = r_we;
  assign bus.data       = r_data;
  assign bus.lines_sent = r_lines_sent;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_rect_cmd_writer.sv
// Directed bench for rect_cmd_writer: a table of requests with hand-computed words and timing,
// followed by hand-written backpressure and mid-request reset sequences.
module tb_rect_cmd_writer;

  logic clk;
  logic reset;
  rect_cmd_writer_if bus ();

  rect_cmd_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [6:0]  top;
    logic [6:0]  bottom;
    logic [7:0]  left;
    logic [7:0]  right;
    logic [2:0]  color;
    logic        swap;
    int          n_lines;
    logic [15:0] hdr0;
    logic [15:0] span;
  } vec_t;

  vec_t        vecs [5];
  logic [15:0] exp_q [$];
  logic [15:0] got_q [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // word monitor: samples what the next rising edge will transfer
  always @(negedge clk) begin
    if (reset && bus.we && !bus.full) got_q.push_back(bus.data);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic compare_words(input string name);
    logic [15:0] g;
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
      check($sformatf("%s_word%0d", name, i), {16'h0, g}, {16'h0, exp_q[i]});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // driver: present one request; returns the cycle stamp of its acceptance edge
  task automatic send_req(input logic [6:0] top, input logic [6:0] bottom,
                          input logic [7:0] left, input logic [7:0] right,
                          input logic [2:0] color, input logic swap, output int acc);
    @(posedge clk);
    #1;
    bus.req_top    = top;
    bus.req_bottom = bottom;
    bus.req_left   = left;
    bus.req_right  = right;
    bus.req_color  = color;
    bus.req_swap   = swap;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    bus.req_valid  = 1'b0;
    bus.req_top    = 7'($urandom_range(0, 119));
    bus.req_bottom = 7'($urandom_range(0, 119));
    bus.req_left   = 8'($urandom_range(0, 159));
    bus.req_right  = 8'($urandom_range(0, 159));
    bus.req_color  = 3'($urandom_range(0, 7));
    bus.req_swap   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input string name, input int acc, output int elapsed);
    int n = 0;
    while (!bus.req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, n);
    end
    elapsed = cyc - acc;
  endtask

  initial begin
    int acc;
    int el;
    int exp_cyc;

    vecs[0] = '{top: 7'd10,  bottom: 7'd12,  left: 8'd20,  right: 8'd40,  color: 3'b101, swap: 1'b0,
                n_lines: 3, hdr0: 16'h280A, span: 16'h1428};
    vecs[1] = '{top: 7'd5,   bottom: 7'd3,   left: 8'd100, right: 8'd2,   color: 3'b001, swap: 1'b0,
                n_lines: 3, hdr0: 16'h0803, span: 16'h0264};
    vecs[2] = '{top: 7'd7,   bottom: 7'd9,   left: 8'd1,   right: 8'd2,   color: 3'b111, swap: 1'b1,
                n_lines: 0, hdr0: 16'h4000, span: 16'h0000};
    vecs[3] = '{top: 7'd50,  bottom: 7'd50,  left: 8'd0,   right: 8'd159, color: 3'b000, swap: 1'b0,
                n_lines: 1, hdr0: 16'h0032, span: 16'h009F};
`ifdef RECT_CMD_CLIP_EN
    vecs[4] = '{top: 7'd118, bottom: 7'd127, left: 8'd150, right: 8'd200, color: 3'b010, swap: 1'b0,
                n_lines: 2, hdr0: 16'h1076, span: 16'h969F};
`else
    vecs[4] = '{top: 7'd118, bottom: 7'd127, left: 8'd150, right: 8'd200, color: 3'b010, swap: 1'b0,
                n_lines: 10, hdr0: 16'h1076, span: 16'h96C8};
`endif

    bus.req_valid  = 1'b0;
    bus.req_top    = 7'd0;
    bus.req_bottom = 7'd0;
    bus.req_left   = 8'd0;
    bus.req_right  = 8'd0;
    bus.req_color  = 3'd0;
    bus.req_swap   = 1'b0;
    bus.full       = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_we",         bus.we,         0);
    check("rst_data",       bus.data,       0);
    check("rst_busy",       bus.busy,       0);
    check("rst_lines_sent", bus.lines_sent, 0);
    check("rst_ready",      bus.req_ready,  0);
    check("rst_state",      bus.dbg_state,  0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rel_ready", bus.req_ready, 1);

    // mid-request reset during the span of line 11
    send_req(7'd10, 7'd12, 8'd20, 8'd40, 3'b101, 1'b0, acc);
    exp_q.push_back(16'h280A);
    exp_q.push_back(16'h1428);
    exp_q.push_back(16'h280B);
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_pre_data", bus.data, 16'h1428);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_we",    bus.we,         0);
    check("rst_mid_data",  bus.data,       0);
    check("rst_mid_busy",  bus.busy,       0);
    check("rst_mid_lines", bus.lines_sent, 0);
    check("rst_mid_ready", bus.req_ready,  0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_mid_rel_ready", bus.req_ready, 1);
    compare_words("rst_mid");

    // table-driven requests
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].swap) begin
        exp_q.push_back(vecs[v].hdr0);
        exp_cyc = 1;
      end else begin
        for (int l = 0; l < vecs[v].n_lines; l++) begin
          exp_q.push_back(vecs[v].hdr0 + 16'(l));
          exp_q.push_back(vecs[v].span);
        end
        exp_cyc = 2 * vecs[v].n_lines;
      end
      send_req(vecs[v].top, vecs[v].bottom, vecs[v].left, vecs[v].right,
               vecs[v].color, vecs[v].swap, acc);
      check($sformatf("vec%0d_first_we", v),   bus.we,   1);
      check($sformatf("vec%0d_first_data", v), bus.data, vecs[v].hdr0);
      check($sformatf("vec%0d_busy", v),       bus.busy, 1);
      check($sformatf("vec%0d_ready_low", v),  bus.req_ready, 0);
      wait_idle($sformatf("vec%0d", v), acc, el);
      check($sformatf("vec%0d_cycles", v),     el, exp_cyc);
      check($sformatf("vec%0d_lines_sent", v), bus.lines_sent, vecs[v].n_lines);
      check($sformatf("vec%0d_idle_busy", v),  bus.busy, 0);
      check($sformatf("vec%0d_idle_we", v),    bus.we,   0);
      compare_words($sformatf("vec%0d", v));
    end

    // backpressure on the first span, with a stray request held up while busy
    send_req(7'd10, 7'd12, 8'd20, 8'd40, 3'b101, 1'b0, acc);
    for (int l = 0; l < 3; l++) begin
      exp_q.push_back(16'h280A + 16'(l));
      exp_q.push_back(16'h1428);
    end
    @(posedge clk);
    #1;
    bus.full       = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_swap   = 1'b1;
    bus.req_top    = 7'd0;
    bus.req_bottom = 7'd100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_we", k),    bus.we,    1);
      check($sformatf("bp_hold%0d_data", k),  bus.data,  16'h1428);
      check($sformatf("bp_hold%0d_ready", k), bus.req_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.full      = 1'b0;
    bus.req_valid = 1'b0;
    wait_idle("bp", acc, el);
    check("bp_cycles",     el, 11);
    check("bp_lines_sent", bus.lines_sent, 3);
    compare_words("bp");

    // full already high when the header is first presented
    bus.full = 1'b1;
    send_req(7'd50, 7'd50, 8'd159, 8'd0, 3'b000, 1'b0, acc);
    exp_q.push_back(16'h0032);
    exp_q.push_back(16'h009F);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("fr_hold%0d_we", k),   bus.we,   1);
      check($sformatf("fr_hold%0d_data", k), bus.data, 16'h0032);
    end
    @(posedge clk);
    #1 bus.full = 1'b0;
    wait_idle("fr", acc, el);
    check("fr_cycles",     el, 5);
    check("fr_lines_sent", bus.lines_sent, 1);
    compare_words("fr");

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
